// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: CSR addresses, the fixed
// misa value and the mstatus field positions.
// Imported by csr_unit and csr_counter64.
package csr_pkg;

    // Machine information registers (read-only)
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // Machine trap setup / handling
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;

    // Machine counters and their user-level read-only shadows
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    // RV32 with the I extension only
    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

    // mstatus field positions
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent software writes to each half.
// Ports: clk/reset, inc_i (+1 this cycle), wr_lo_i/wr_hi_i (load wr_data_i into
// that half), cnt_o (current count). A written half takes the write data and
// skips the increment; the other half still sees the increment and its carry.
module csr_counter64 (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wr_data_i,
    output logic [63:0] cnt_o
);

    logic [63:0] cnt_q;
    logic [63:0] cnt_d;
    logic [63:0] cnt_inc;

    always_comb begin
        cnt_inc = cnt_q + {63'd0, inc_i};
        cnt_d   = cnt_inc;
        if (wr_lo_i) cnt_d[31:0]  = wr_data_i;
        if (wr_hi_i) cnt_d[63:32] = wr_data_i;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file with trap entry / MRET sequencing for the RV32I core.
// Ports: Zicsr access (csrEn/csrAddr/csrWr/csrWrData -> csrRdData/illegalCsr),
// trap control (exception/excCode/mret/pc -> pcRedirect/pcTarget), instRetire.
// Reads, illegalCsr and the redirect are combinational; state updates on the
// rising edge with priority exception > mret > CSR write.
// Optional feature macro CSR_COUNTERS_EN: adds mcycle/minstret 64-bit counters
// and their cycle/instret shadows; without it those addresses read 0 and
// ignore writes.
module csr_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csrEn,
    input  logic [11:0] csrAddr,
    input  logic        csrWr,
    input  logic [31:0] csrWrData,
    output logic [31:0] csrRdData,
    output logic        illegalCsr,
    input  logic        exception,
    input  logic [30:0] excCode,
    input  logic        mret,
    input  logic [31:0] pc,
    input  logic        instRetire,
    output logic        pcRedirect,
    output logic [31:0] pcTarget
);

    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    // mtvec and mepc keep their low two bits in the flops; they are masked
    // on every read so both always appear word aligned.
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;

    logic [31:0] mtvec_rd;
    logic [31:0] mepc_rd;
    logic        csr_impl;
    logic        ctr_addr;
    logic        ro_wr;
    logic [31:0] rd_val;
    logic        wr_ok;

    assign mtvec_rd = {mtvec_q[31:2], 2'b00};
    assign mepc_rd  = {mepc_q[31:2], 2'b00};

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle;
    logic [63:0] minstret;
`else
    logic unused_inst_retire;
    assign unused_inst_retire = instRetire;
`endif

    // Address decode and read mux
    always_comb begin
        csr_impl = 1'b1;
        ctr_addr = 1'b0;
        rd_val   = '0;
        case (csrAddr)
            CSR_MSTATUS: begin
                rd_val[MSTATUS_MIE]                   = mie_q;
                rd_val[MSTATUS_MPIE]                  = mpie_q;
                rd_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
            end
            CSR_MISA:      rd_val = MISA_VALUE;
            CSR_MVENDORID: rd_val = '0;
            CSR_MARCHID:   rd_val = '0;
            CSR_MIMPID:    rd_val = '0;
            CSR_MHARTID:   rd_val = HART_ID;
            CSR_MTVEC:     rd_val = mtvec_rd;
            CSR_MSCRATCH:  rd_val = mscratch_q;
            CSR_MEPC:      rd_val = mepc_rd;
            CSR_MCAUSE:    rd_val = mcause_q;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE,   CSR_CYCLE:    rd_val = mcycle[31:0];
            CSR_MCYCLEH,  CSR_CYCLEH:   rd_val = mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:  rd_val = minstret[31:0];
            CSR_MINSTRETH,CSR_INSTRETH: rd_val = minstret[63:32];
`else
            // Counter space decodes as present but empty so software probing
            // it does not trap.
            CSR_MCYCLE, CSR_CYCLE, CSR_MCYCLEH, CSR_CYCLEH,
            CSR_MINSTRET, CSR_INSTRET, CSR_MINSTRETH, CSR_INSTRETH: begin
                rd_val   = '0;
                ctr_addr = 1'b1;
            end
`endif
            default: csr_impl = 1'b0;
        endcase
    end

    // Writes into the 0xC00-0xFFF read-only space trap, as do writes to misa
    // (it is fixed here). Without counters the empty counter space never traps.
    assign ro_wr      = csrWr & ((csrAddr[11:10] == 2'b11) | (csrAddr == CSR_MISA)) & ~ctr_addr;
    assign illegalCsr = csrEn & (~csr_impl | ro_wr);
    assign csrRdData  = illegalCsr ? 32'd0 : rd_val;

    // Trap entry and MRET take the cycle; any CSR write alongside is dropped.
    assign wr_ok = csrEn & csrWr & ~illegalCsr & ~exception & ~mret;

    assign pcRedirect = exception | mret;
    assign pcTarget   = exception ? mtvec_rd : mepc_rd;

    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        if (exception) begin
            mepc_d   = pc;
            mcause_d = {1'b0, excCode};
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (wr_ok) begin
            case (csrAddr)
                CSR_MSTATUS: begin
                    mie_d  = csrWrData[MSTATUS_MIE];
                    mpie_d = csrWrData[MSTATUS_MPIE];
                end
                CSR_MTVEC:    mtvec_d    = csrWrData;
                CSR_MSCRATCH: mscratch_d = csrWrData;
                CSR_MEPC:     mepc_d     = csrWrData;
                CSR_MCAUSE:   mcause_d   = csrWrData;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

`ifdef CSR_COUNTERS_EN
    csr_counter64 u_mcycle (
        .clk       (clk),
        .reset     (reset),
        .inc_i     (1'b1),
        .wr_lo_i   (wr_ok & (csrAddr == CSR_MCYCLE)),
        .wr_hi_i   (wr_ok & (csrAddr == CSR_MCYCLEH)),
        .wr_data_i (csrWrData),
        .cnt_o     (mcycle)
    );

    // A trapping instruction does not retire.
    csr_counter64 u_minstret (
        .clk       (clk),
        .reset     (reset),
        .inc_i     (instRetire & ~exception),
        .wr_lo_i   (wr_ok & (csrAddr == CSR_MINSTRET)),
        .wr_hi_i   (wr_ok & (csrAddr == CSR_MINSTRETH)),
        .wr_data_i (csrWrData),
        .cnt_o     (minstret)
    );
`endif

endmodule
